// File: rtl/pos_acc_shifted.sv
// Sequential shifted accumulator: sums unsigned terms, each shifted left by a per-term amount.
// Define POS_ACC_SUB_EN to honour in_sub (subtract the shifted term instead of adding it).
module pos_acc_shifted #(
   parameter int N_BITS_IN  = 16,
   parameter int N_BITS_ACC = 32,
   parameter int SHIFT_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_BITS_IN-1:0]  in_data,
   input  logic [SHIFT_W-1:0]    in_shift,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N_BITS_ACC-1:0] out_data,
   output logic                  out_ovf
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

   localparam int               EXT_W   = N_BITS_ACC + N_BITS_IN;
   localparam logic [SHIFT_W:0] ACC_W_S = (SHIFT_W + 1)'(N_BITS_ACC);

   state_e                state_q;
   logic [N_BITS_ACC-1:0] acc_q, out_data_q;
   logic                  ovf_q, out_valid_q, out_ovf_q;

   logic                  sub_en;
   logic [EXT_W-1:0]      ext;
   logic [N_BITS_ACC-1:0] term, base, acc_d;
   logic [N_BITS_ACC:0]   sum;
   logic                  trunc, load, ovf_d, accept;

`ifdef POS_ACC_SUB_EN
   assign sub_en = in_sub;
`else
   logic unused_in_sub;
   assign unused_in_sub = in_sub;
   assign sub_en        = 1'b0;
`endif

   assign in_ready  = ~out_valid_q;
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

   // ext is wide enough that no in_data bit is lost for any shift below N_BITS_ACC,
   // so the bits above the accumulator width are exactly the truncated ones.
   always_comb begin
      ext   = EXT_W'(in_data) << in_shift;
      term  = '0;
      trunc = 1'b0;
      if ({1'b0, in_shift} >= ACC_W_S) begin
         trunc = |in_data;
      end else begin
         term  = ext[N_BITS_ACC-1:0];
         trunc = |ext[EXT_W-1:N_BITS_ACC];
      end

      load = in_first || (state_q == IDLE);
      base = load ? '0 : acc_q;
      if (sub_en) begin
         sum = {1'b0, base} - {1'b0, term};
      end else begin
         sum = {1'b0, base} + {1'b0, term};
      end
      acc_d = sum[N_BITS_ACC-1:0];
      ovf_d = (load ? 1'b0 : ovf_q) | trunc | sum[N_BITS_ACC];
   end

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order within the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  ovf_q <= ovf_d;
                  if (in_last) begin
                     out_data_q  <= acc_d;
                     out_ovf_q   <= ovf_d;
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end else begin
                     state_q     <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  ovf_q       <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pos_acc_shifted.sv
// Directed and randomized bench for pos_acc_shifted; a reference model fills a
// scoreboard queue as terms are accepted, results are popped when presented.
module tb_pos_acc_shifted;

   localparam int IW = 16;
   localparam int AW = 32;
   localparam int SW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_data = '0;
   logic [SW-1:0] in_shift = '0;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic          in_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_data;
   logic          out_ovf;

   typedef struct packed {
      logic          ovf;
      logic [AW-1:0] data;
   } res_t;

   res_t          sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [AW-1:0] m_acc;
   logic          m_ovf;
   logic          m_idle;

   always #5 clk = ~clk;

   pos_acc_shifted #(.N_BITS_IN(IW), .N_BITS_ACC(AW), .SHIFT_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc  = '0;
      m_ovf  = 1'b0;
      m_idle = 1'b1;
   endtask

   // Exact-width arithmetic: the term is built in 128 bits so nothing is lost before truncation.
   task automatic model_term(input logic [IW-1:0] d, input logic [SW-1:0] s,
                             input bit f, input bit l, input bit sub);
      logic [127:0]  full;
      logic [AW-1:0] t, base;
      logic [AW:0]   r;
      logic          tr, ld, do_sub;
      full = 128'(d) << s;
      t    = full[AW-1:0];
      tr   = |full[127:AW];
      ld   = f || m_idle;
      base = ld ? '0 : m_acc;
`ifdef POS_ACC_SUB_EN
      do_sub = sub;
`else
      do_sub = 1'b0;
`endif
      r      = do_sub ? ({1'b0, base} - {1'b0, t}) : ({1'b0, base} + {1'b0, t});
      m_ovf  = (ld ? 1'b0 : m_ovf) | tr | r[AW];
      m_acc  = r[AW-1:0];
      m_idle = 1'b0;
      if (l) begin
         sb.push_back({m_ovf, m_acc});
         model_reset();
      end
   endtask

   task automatic send(input logic [IW-1:0] d, input logic [SW-1:0] s,
                       input bit f, input bit l, input bit sub);
      int w = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_shift = s;
      in_first = f;
      in_last  = l;
      in_sub   = sub;
      while (!in_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("in_ready_before_accept", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      in_sub   = 1'b0;
      model_term(d, s, f, l, sub);
   endtask

   task automatic get_result(input string tag, input bit use_const,
                             input logic [AW-1:0] c_data, input logic c_ovf);
      res_t exp;
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 64'(0), 64'(1));
      end else begin
         exp = sb.pop_front();
         check({tag, "_data"}, 64'(out_data), 64'(exp.data));
         check({tag, "_ovf"}, 64'(out_ovf), 64'(exp.ovf));
      end
      if (use_const) begin
         check({tag, "_data_const"}, 64'(out_data), 64'(c_data));
         check({tag, "_ovf_const"}, 64'(out_ovf), 64'(c_ovf));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_ovf", 64'(out_ovf), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(16'hABCD, 0, 1, 1, 0);
      get_result("single", 1, 32'h0000ABCD, 1'b0);

      send(16'h1234, 16, 1, 0, 0);
      send(16'h0056, 8, 0, 0, 0);
      send(16'h0078, 0, 0, 1, 0);
      get_result("karatsuba", 1, 32'h12345678, 1'b0);

      send(16'hFFFF, 24, 1, 1, 0);
      get_result("trunc_bits", 1, 32'hFF000000, 1'b1);

      send(16'hFFFF, 16, 1, 0, 0);
      send(16'h0001, 16, 0, 1, 0);
      get_result("carry_out", 1, 32'h00000000, 1'b1);

      send(16'h0003, 40, 1, 1, 0);
      get_result("over_shift", 1, 32'h00000000, 1'b1);
      send(16'h0000, 40, 1, 1, 0);
      get_result("over_shift_zero", 1, 32'h00000000, 1'b0);

      send(16'hFFFF, 24, 1, 0, 0);
      send(16'h0005, 0, 1, 1, 0);
      get_result("first_discards", 1, 32'h00000005, 1'b0);

      send(16'h0010, 4, 1, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      send(16'h0001, 0, 0, 1, 0);
      get_result("accum_idle_gap", 1, 32'h00000101, 1'b0);

      send(16'h0100, 0, 1, 0, 0);
      send(16'h0001, 0, 0, 1, 1);
`ifdef POS_ACC_SUB_EN
      get_result("sub", 1, 32'h000000FF, 1'b0);
`else
      get_result("sub_ignored", 1, 32'h00000101, 1'b0);
`endif

      // Back-pressure: result held, a waiting term must not be taken until IDLE.
      send(16'h4321, 0, 1, 1, 0);
      in_valid = 1'b1;
      in_data  = 16'h0005;
      in_shift = '0;
      in_first = 1'b0;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_in_ready", 64'(in_ready), 64'(0));
         check("hold_out_valid", 64'(out_valid), 64'(1));
         check("hold_out_data", 64'(out_data), 64'(32'h4321));
      end
      get_result("hold_result", 1, 32'h00004321, 1'b0);
      check("after_hs_in_ready", 64'(in_ready), 64'(1));
      check("after_hs_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_term(16'h0005, 0, 0, 1, 0);
      get_result("idle_loads", 1, 32'h00000005, 1'b0);

      send(16'h7777, 0, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midsum_rst_out_valid", 64'(out_valid), 64'(0));
      check("midsum_rst_out_data", 64'(out_data), 64'(0));
      check("midsum_rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(16'h0009, 0, 0, 1, 0);
      get_result("after_midsum_rst", 1, 32'h00000009, 1'b0);

      send(16'h0055, 0, 1, 1, 0);
      @(negedge clk);
      check("pre_hold_rst_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      model_reset();
      check("hold_rst_out_valid", 64'(out_valid), 64'(0));
      check("hold_rst_out_data", 64'(out_data), 64'(0));
      check("hold_rst_out_ovf", 64'(out_ovf), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int n = 0; n < 12; n++) begin
         int terms;
         terms = $urandom_range(1, 4);
         for (int k = 0; k < terms; k++) begin
            send(IW'($urandom_range(0, 65535)), SW'($urandom_range(0, 40)),
                 (k == 0) || ($urandom_range(0, 7) == 0), k == terms - 1,
                 1'($urandom_range(0, 1)));
         end
         get_result("random", 0, '0, 1'b0);
      end

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
